// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: ALU results take the write port first, LSU results
// wait in a DEPTH-entry in-order buffer. Optional WB_PENDING_MASK_EN exports pending writes.
module reg_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        regWEn,
    output logic [4:0]  rd,
    output logic [31:0] DataD,
    output logic [31:0] pending_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]          wr_ptr_reg;
    logic [PW-1:0]          rd_ptr_reg;
    logic [CW-1:0]          count_reg;
    logic [CW-1:0]          count_next;
    logic [DEPTH-1:0]       entry_valid_reg;
    logic [DEPTH-1:0]       entry_valid_next;
    logic [DEPTH-1:0][4:0]  entry_rd_reg;
    logic [DEPTH-1:0][4:0]  entry_rd_next;
    logic [DEPTH-1:0][31:0] entry_data_reg;
    logic [DEPTH-1:0][31:0] entry_data_next;
    logic [DEPTH-1:0]       wr_sel;
    logic [DEPTH-1:0]       pop_sel;
    logic [DEPTH-1:0]       kill_hit;

    logic        wen_reg;
    logic [4:0]  rd_reg;
    logic [31:0] data_reg;

    logic        alu_hit;
    logic        lsu_fire;
    logic        fifo_empty;
    logic        pop;
    logic        bypass;
    logic        enq;
    logic        enq_valid;
    logic        head_valid;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    assign lsu_ready  = (count_reg != CW'(DEPTH)) && !rst;
    assign alu_hit    = alu_valid && (alu_rd != 5'd0);
    assign lsu_fire   = lsu_valid && lsu_ready;
    assign fifo_empty = (count_reg == '0);

    assign head_valid = entry_valid_reg[rd_ptr_reg];
    assign head_rd    = entry_rd_reg[rd_ptr_reg];
    assign head_data  = entry_data_reg[rd_ptr_reg];

    // A head entry pops whenever the ALU leaves the port free, even if it was killed.
    assign pop    = !alu_hit && !fifo_empty;
    assign bypass = !alu_hit && fifo_empty && lsu_fire && (lsu_rd != 5'd0);
    assign enq    = lsu_fire && !bypass && (lsu_rd != 5'd0);
    // An LSU result overtaken by a same-cycle ALU write to the same register is stored dead.
    assign enq_valid = !(alu_hit && (lsu_rd == alu_rd));

    assign count_next = count_reg + CW'(enq) - CW'(pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wr_sel[gi]   = enq && (wr_ptr_reg == PW'(gi));
            assign pop_sel[gi]  = pop && (rd_ptr_reg == PW'(gi));
            assign kill_hit[gi] = alu_hit && (entry_rd_reg[gi] == alu_rd);
            // Valid bits are cleared on pop so only live, unkilled entries ever read as valid.
            assign entry_valid_next[gi] = wr_sel[gi] ? enq_valid
                                        : (entry_valid_reg[gi] && !pop_sel[gi] && !kill_hit[gi]);
            assign entry_rd_next[gi]    = wr_sel[gi] ? lsu_rd   : entry_rd_reg[gi];
            assign entry_data_next[gi]  = wr_sel[gi] ? lsu_data : entry_data_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            entry_valid_reg <= '0;
        end else begin
            wr_ptr_reg      <= wr_ptr_reg + PW'(enq);
            rd_ptr_reg      <= rd_ptr_reg + PW'(pop);
            count_reg       <= count_next;
            entry_valid_reg <= entry_valid_next;
        end
        entry_rd_reg   <= entry_rd_next;
        entry_data_reg <= entry_data_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_reg  <= 1'b0;
            rd_reg   <= 5'd0;
            data_reg <= 32'd0;
        end else if (alu_hit) begin
            wen_reg  <= 1'b1;
            rd_reg   <= alu_rd;
            data_reg <= alu_data;
        end else if (pop) begin
            wen_reg <= head_valid;
            if (head_valid) begin
                rd_reg   <= head_rd;
                data_reg <= head_data;
            end
        end else if (bypass) begin
            wen_reg  <= 1'b1;
            rd_reg   <= lsu_rd;
            data_reg <= lsu_data;
        end else begin
            wen_reg <= 1'b0;
        end
    end

    assign regWEn = wen_reg;
    assign rd     = rd_reg;
    assign DataD  = data_reg;

`ifdef WB_PENDING_MASK_EN
    logic [31:0][DEPTH-1:0] mask_hits;
    logic [31:0]            mask_next;
    logic [31:0]            mask_reg;

    genvar gj;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_mask_bit
            for (gj = 0; gj < DEPTH; gj++) begin : g_mask_entry
                assign mask_hits[gi][gj] = entry_valid_next[gj] && (entry_rd_next[gj] == 5'(gi));
            end
            assign mask_next[gi] = |mask_hits[gi];
        end
    endgenerate

    // Built from next-state contents so the mask matches the FIFO right after each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= 32'd0;
        end else begin
            mask_reg <= mask_next;
        end
    end

    assign pending_mask = mask_reg;
`else
    assign pending_mask = 32'h0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: expected writes queued in output order, a negedge
// monitor pops and compares every register-file write; state checks are made inline.
module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        regWEn;
    logic [4:0]  rd;
    logic [31:0] DataD;
    logic [31:0] pending_mask;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t mon_exp;
    int  checks = 0;
    int  fails  = 0;

    reg_wb_arbiter #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .regWEn       (regWEn),
        .rd           (rd),
        .DataD        (DataD),
        .pending_mask (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_mask(input logic [31:0] m);
`ifdef WB_PENDING_MASK_EN
        return m;
`else
        return 32'h0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        wr_t w;
        w.rd   = r;
        w.data = d;
        sb.push_back(w);
    endtask

    // Every register-file write must match the next queued expectation.
    always @(negedge clk) begin
        if (regWEn) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got x%0d=%h, required no write", rd, DataD);
            end else begin
                mon_exp = sb.pop_front();
                if (rd !== mon_exp.rd || DataD !== mon_exp.data) begin
                    fails++;
                    $display("FAIL wb_write: got x%0d=%h, required x%0d=%h",
                             rd, DataD, mon_exp.rd, mon_exp.data);
                end else begin
                    $display("wb write x%0d = %h", rd, DataD);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();

        // Reset release
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_wen", {31'd0, regWEn}, 32'd0);
            check("rst_rd", {27'd0, rd}, 32'd0);
            check("rst_data", DataD, 32'd0);
            check("rst_mask", pending_mask, 32'd0);
            check("rst_ready", {31'd0, lsu_ready}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, lsu_ready}, 32'd1);

        // ALU priority with buffering
        expect_wr(5'd5, 32'h11);
        expect_wr(5'd6, 32'h22);
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
        tick();
        idle();
        check("prio_wen", {31'd0, regWEn}, 32'd1);
        check("prio_rd", {27'd0, rd}, 32'd5);
        check("prio_mask_set", pending_mask, exp_mask(32'h0000_0040));
        tick();
        check("prio_lsu_rd", {27'd0, rd}, 32'd6);
        check("prio_mask_clr", pending_mask, 32'd0);
        tick();
        check("prio_idle", {31'd0, regWEn}, 32'd0);

        // Full FIFO and back-pressure
        expect_wr(5'd1, 32'h101);
        expect_wr(5'd1, 32'h102);
        expect_wr(5'd1, 32'h103);
        expect_wr(5'd1, 32'h104);
        expect_wr(5'd7, 32'h77);
        expect_wr(5'd8, 32'h88);
        expect_wr(5'd9, 32'h99);
        drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd7, 32'h77);
        check("bp_ready0", {31'd0, lsu_ready}, 32'd1);
        tick();
        drive(1'b1, 5'd1, 32'h102, 1'b1, 5'd8, 32'h88);
        check("bp_ready1", {31'd0, lsu_ready}, 32'd1);
        tick();
        check("bp_mask_full", pending_mask, exp_mask(32'h0000_0180));
        drive(1'b1, 5'd1, 32'h103, 1'b1, 5'd9, 32'h99);
        check("bp_ready_full0", {31'd0, lsu_ready}, 32'd0);
        tick();
        drive(1'b1, 5'd1, 32'h104, 1'b1, 5'd9, 32'h99);
        check("bp_ready_full1", {31'd0, lsu_ready}, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        check("bp_ready_full2", {31'd0, lsu_ready}, 32'd0);
        tick();
        check("bp_ready_after_pop", {31'd0, lsu_ready}, 32'd1);
        tick();
        idle();
        tick();
        tick();
        check("bp_drained_wen", {31'd0, regWEn}, 32'd0);
        check("bp_drained_ready", {31'd0, lsu_ready}, 32'd1);

        // WAW kill of a buffered entry
        expect_wr(5'd2, 32'h55);
        expect_wr(5'd10, 32'hBB);
        drive(1'b1, 5'd2, 32'h55, 1'b1, 5'd10, 32'hAA);
        tick();
        check("waw_mask_set", pending_mask, exp_mask(32'h0000_0400));
        drive(1'b1, 5'd10, 32'hBB, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        check("waw_mask_clr", pending_mask, 32'd0);
        check("waw_alu_data", DataD, 32'hBB);
        tick();
        check("waw_killed_pop_wen", {31'd0, regWEn}, 32'd0);
        check("waw_hold_rd", {27'd0, rd}, 32'd10);
        check("waw_hold_data", DataD, 32'hBB);
        tick();

        // Same-cycle enqueue overtaken by the ALU write
        expect_wr(5'd12, 32'hC1);
        drive(1'b1, 5'd12, 32'hC1, 1'b1, 5'd12, 32'hC2);
        tick();
        idle();
        check("samecyc_mask", pending_mask, 32'd0);
        tick();
        check("samecyc_killed_pop", {31'd0, regWEn}, 32'd0);
        check("samecyc_hold_data", DataD, 32'hC1);
        tick();

        // x0 suppression and LSU bypass
        expect_wr(5'd3, 32'h33);
        drive(1'b1, 5'd0, 32'hFF, 1'b1, 5'd3, 32'h33);
        tick();
        check("x0_bypass_wen", {31'd0, regWEn}, 32'd1);
        check("x0_bypass_rd", {27'd0, rd}, 32'd3);
        check("x0_bypass_data", DataD, 32'h33);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99);
        check("lsu_x0_ready", {31'd0, lsu_ready}, 32'd1);
        tick();
        idle();
        check("lsu_x0_dropped", {31'd0, regWEn}, 32'd0);
        check("lsu_x0_hold", DataD, 32'h33);
        tick();
        check("lsu_x0_not_queued", {31'd0, regWEn}, 32'd0);

        // Reset mid-queue
        expect_wr(5'd4, 32'h44);
        expect_wr(5'd4, 32'h45);
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd13, 32'hD1);
        tick();
        drive(1'b1, 5'd4, 32'h45, 1'b1, 5'd14, 32'hD2);
        tick();
        check("midq_mask", pending_mask, exp_mask(32'h0000_6000));
        check("midq_full", {31'd0, lsu_ready}, 32'd0);
        idle();
        rst = 1'b1;
        tick();
        check("midq_rst_wen", {31'd0, regWEn}, 32'd0);
        check("midq_rst_rd", {27'd0, rd}, 32'd0);
        check("midq_rst_data", DataD, 32'd0);
        check("midq_rst_mask", pending_mask, 32'd0);
        rst = 1'b0;
        #1;
        check("midq_ready", {31'd0, lsu_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midq_no_write", {31'd0, regWEn}, 32'd0);
            check("midq_mask_zero", pending_mask, 32'd0);
        end

        @(negedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
